// File: rtl/adm1176_pkg.sv
// ADM1176 poller shared definitions.
// Command opcodes, device constant, FSM and step enums.
package adm1176_pkg;

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_RACK  = 3'd2;
  localparam logic [2:0] OP_RNACK = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;

  // Command byte: start V and I conversions, continuous.
  localparam logic [7:0] ADM_CMD_CFG = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_RESP,
    ST_ADV
  } state_t;

  typedef enum logic [2:0] {
    S_CSTART,
    S_CWRITE,
    S_CSTOP,
    S_RSTART,
    S_RA0,
    S_RA1,
    S_RN2,
    S_RSTOP
  } step_t;

endpackage

// File: rtl/adm1176_seq.sv
// ADM1176 step sequencer: maps a step to its bus command,
// the following step and the STOP step used after a NACK.
module adm1176_seq
  import adm1176_pkg::*;
(
  input  step_t       step_i,
  input  logic [6:0]  adr_i,
  output logic [2:0]  op_o,
  output logic [7:0]  data_o,
  output step_t       next_o,
  output step_t       skip_o,
  output logic        nack_chk_o,
  output logic        stop_o
);

  // Step decode table.
  always_comb begin
    op_o       = OP_STOP;
    data_o     = 8'h00;
    next_o     = S_CSTART;
    skip_o     = S_RSTOP;
    nack_chk_o = 1'b0;
    stop_o     = 1'b0;
    unique case (step_i)
      S_CSTART: begin
        op_o       = OP_START;
        data_o     = {adr_i, 1'b0};
        next_o     = S_CWRITE;
        skip_o     = S_CSTOP;
        nack_chk_o = 1'b1;
      end
      S_CWRITE: begin
        op_o       = OP_WRITE;
        data_o     = ADM_CMD_CFG;
        next_o     = S_CSTOP;
        skip_o     = S_CSTOP;
        nack_chk_o = 1'b1;
      end
      S_CSTOP: begin
        next_o = S_RSTART;
        skip_o = S_CSTOP;
        stop_o = 1'b1;
      end
      S_RSTART: begin
        op_o       = OP_START;
        data_o     = {adr_i, 1'b1};
        next_o     = S_RA0;
        nack_chk_o = 1'b1;
      end
      S_RA0: begin
        op_o   = OP_RACK;
        next_o = S_RA1;
      end
      S_RA1: begin
        op_o   = OP_RACK;
        next_o = S_RN2;
      end
      S_RN2: begin
        op_o   = OP_RNACK;
        next_o = S_RSTOP;
      end
      S_RSTOP: begin
        stop_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/adm1176_poller.sv
// ADM1176 round-robin poller over a byte-level bus master.
// Build option: ADM1176_POLLER_WATCHDOG_EN adds a response watchdog.
module adm1176_poller
  import adm1176_pkg::*;
#(
  parameter int                   NUM_DEV        = 2,
  parameter logic [7*NUM_DEV-1:0] DEV_ADRS       = {7'h4A, 7'h48},
  parameter int                   PERIOD_CYCLES  = 100000,
  parameter int                   TIMEOUT_CYCLES = 65535
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_op_o,
  output logic [7:0]            cmd_data_o,
  input  logic                  rsp_valid_i,
  input  logic [7:0]            rsp_data_i,
  input  logic                  rsp_nack_i,
  output logic [12*NUM_DEV-1:0] mvolt_o,
  output logic [12*NUM_DEV-1:0] mamp_o,
  output logic [NUM_DEV-1:0]    valid_o,
  output logic [NUM_DEV-1:0]    err_o,
  output logic                  update_o
);

  localparam int DW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam logic [31:0]   PER_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [DW-1:0] DEV_LAST = DW'(NUM_DEV - 1);

  state_t state_q, state_d;
  step_t  step_q, step_d;
  logic [DW-1:0] dev_q, dev_d, dev_nx;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic err_pend_q, err_pend_d;
  logic done_q, done_d;
  logic upd_q, upd_d;
  logic [NUM_DEV-1:0] cfg_q, cfg_d;
  logic [NUM_DEV-1:0] valid_q, valid_d;
  logic [NUM_DEV-1:0] err_q, err_d;
  logic [12*NUM_DEV-1:0] mvolt_q, mvolt_d;
  logic [12*NUM_DEV-1:0] mamp_q, mamp_d;
`ifdef ADM1176_POLLER_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_q, wd_d;
`endif

  logic [6:0] adr;
  logic [2:0] seq_op;
  logic [7:0] seq_data;
  step_t      seq_next, seq_skip;
  logic       seq_chk, seq_stop;

  assign adr    = DEV_ADRS[7*int'(dev_q) +: 7];
  assign dev_nx = dev_q + DW'(1);

  adm1176_seq u_seq (
    .step_i     (step_q),
    .adr_i      (adr),
    .op_o       (seq_op),
    .data_o     (seq_data),
    .next_o     (seq_next),
    .skip_o     (seq_skip),
    .nack_chk_o (seq_chk),
    .stop_o     (seq_stop)
  );

  assign cmd_valid_o = (state_q == ST_ISSUE);
  assign cmd_op_o    = cmd_valid_o ? seq_op : 3'd0;
  assign cmd_data_o  = cmd_valid_o ? seq_data : 8'h00;
  assign mvolt_o     = mvolt_q;
  assign mamp_o      = mamp_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign update_o    = upd_q;

  // Poll FSM: next state, step advance and result capture.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    dev_d      = dev_q;
    cnt_d      = cnt_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    err_pend_d = err_pend_q;
    done_d     = done_q;
    upd_d      = 1'b0;
    cfg_d      = cfg_q;
    valid_d    = valid_q;
    err_d      = err_q;
    mvolt_d    = mvolt_q;
    mamp_d     = mamp_q;
`ifdef ADM1176_POLLER_WATCHDOG_EN
    wd_d       = wd_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == PER_LAST) begin
          state_d    = ST_ISSUE;
          dev_d      = '0;
          step_d     = cfg_q[0] ? S_RSTART : S_CSTART;
          err_pend_d = 1'b0;
          done_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready_i) begin
          state_d = ST_RESP;
`ifdef ADM1176_POLLER_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_valid_i) begin
          state_d = ST_ADV;
          if (seq_chk && rsp_nack_i) begin
            step_d       = seq_skip;
            err_pend_d   = 1'b1;
            err_d[dev_q] = 1'b1;
            cfg_d[dev_q] = 1'b0;
          end else begin
            step_d = seq_next;
            unique case (step_q)
              S_RA0: b0_d = rsp_data_i;
              S_RA1: b1_d = rsp_data_i;
              S_RN2: b2_d = rsp_data_i;
              S_CSTOP: begin
                if (err_pend_q) done_d = 1'b1;
                else cfg_d[dev_q] = 1'b1;
              end
              S_RSTOP: begin
                done_d = 1'b1;
                if (!err_pend_q) begin
                  mvolt_d[12*int'(dev_q) +: 12] = {b0_q, b2_q[7:4]};
                  mamp_d[12*int'(dev_q) +: 12]  = {b1_q, b2_q[3:0]};
                  valid_d[dev_q] = 1'b1;
                  err_d[dev_q]   = 1'b0;
                  upd_d          = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
`ifdef ADM1176_POLLER_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          state_d      = ST_ADV;
          err_pend_d   = 1'b1;
          err_d[dev_q] = 1'b1;
          cfg_d[dev_q] = 1'b0;
          // A silent STOP cannot be retried; give up on the device.
          if (seq_stop) done_d = 1'b1;
          else step_d = seq_skip;
        end else begin
          wd_d = wd_q + 32'd1;
        end
`endif
      end
      ST_ADV: begin
        if (!done_q) begin
          state_d = ST_ISSUE;
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (dev_q == DEV_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d    = ST_ISSUE;
          dev_d      = dev_nx;
          step_d     = cfg_q[dev_nx] ? S_RSTART : S_CSTART;
          err_pend_d = 1'b0;
          done_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      step_q     <= S_CSTART;
      dev_q      <= '0;
      cnt_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      upd_q      <= 1'b0;
      cfg_q      <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      mvolt_q    <= '0;
      mamp_q     <= '0;
`ifdef ADM1176_POLLER_WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dev_q      <= dev_d;
      cnt_q      <= cnt_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      err_pend_q <= err_pend_d;
      done_q     <= done_d;
      upd_q      <= upd_d;
      cfg_q      <= cfg_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      mvolt_q    <= mvolt_d;
      mamp_q     <= mamp_d;
`ifdef ADM1176_POLLER_WATCHDOG_EN
      wd_q       <= wd_d;
`endif
    end
  end

endmodule
